// File: rtl/mem_arb.sv
// mem_arb: two-port round-robin arbiter and sequencer in front of a single-port
// 24-bit synchronous memory with a one-cycle registered read.
//   port 0 : instruction fetch, read only
//   port 1 : load/store unit, reads and writes, may lock for read-modify-write
//
// Handshake: a requester raises req with addr (and we/wdata on port 1) and
// holds all of them stable until it sees gnt high in the same cycle; the
// transfer happens in the cycle where req & gnt are both high. Dropping req
// before gnt is legal and leaves no trace. Out-of-range requests are also
// granted, so the requester retires them. They are never sent to the memory
// and raise or_err in the following cycle instead.

`ifndef HBIT_ADDR
`define HBIT_ADDR 15
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 23
`endif

module mem_arb #(
   parameter int NUM_WORDS = 4096
) (
   input  logic                iw_clk,
   input  logic                iw_rst,
   // port 0: instruction fetch
   input  logic                iw_req0,
   input  logic [`HBIT_ADDR:0] iw_addr0,
   output logic                ow_gnt0,
   output logic                or_rvalid0,
   // port 1: load/store
   input  logic                iw_req1,
   input  logic                iw_we1,
   input  logic [`HBIT_ADDR:0] iw_addr1,
   input  logic [`HBIT_DATA:0] iw_wdata1,
   input  logic                iw_lock1,
   output logic                ow_gnt1,
   output logic                or_rvalid1,
   // shared read return and error pulse
   output logic [`HBIT_DATA:0] ow_rdata,
   output logic                or_err,
   // memory side
   output logic                ow_mem_we,
   output logic [`HBIT_ADDR:0] ow_mem_addr,
   output logic [`HBIT_DATA:0] ow_mem_wdata,
   input  logic [`HBIT_DATA:0] iw_mem_rdata
);

   localparam logic [31:0] LIMIT = 32'(NUM_WORDS);

   // r_last: port that received the most recent real memory access (1 = port 1).
   // r_locked: port 1 keeps priority for its next request.
   logic                r_last;
   logic                r_locked;
   logic                r_rvalid0;
   logic                r_rvalid1;
   logic                r_err;
   logic [`HBIT_ADDR:0] r_addr;

   logic w_ok0;
   logic w_ok1;
   logic w_sel1;
   logic w_acc0;
   logic w_acc1;
   logic w_rej;

   // Both addresses are range-checked independently of arbitration.
   assign w_ok0 = (32'(iw_addr0) < LIMIT);
   assign w_ok1 = (32'(iw_addr1) < LIMIT);

   // Arbitration: a lone requester wins; on a tie the lock favours port 1,
   // otherwise the port that did not win last time goes next.
   always_comb begin
      w_sel1 = 1'b0;
      if (iw_req1 && (!iw_req0 || r_locked || !r_last)) begin
         w_sel1 = 1'b1;
      end
   end

   // Grants are held low through reset so nothing is consumed while resetting.
   assign ow_gnt1 = w_sel1 & ~iw_rst;
   assign ow_gnt0 = iw_req0 & ~w_sel1 & ~iw_rst;

   // Accepted accesses reach the memory; rejected ones only produce an error.
   assign w_acc0 = ow_gnt0 & w_ok0;
   assign w_acc1 = ow_gnt1 & w_ok1;
   assign w_rej  = (ow_gnt0 & ~w_ok0) | (ow_gnt1 & ~w_ok1);

   // Memory address follows the accepted port, otherwise holds its last value
   // so the memory sees a quiet bus when idle.
   always_comb begin
      ow_mem_addr = r_addr;
      if (w_acc1) begin
         ow_mem_addr = iw_addr1;
      end else if (w_acc0) begin
         ow_mem_addr = iw_addr0;
      end
   end

   assign ow_mem_we    = w_acc1 & iw_we1;
   assign ow_mem_wdata = iw_wdata1;

   // Read data comes straight from the memory's output register; the rvalid
   // flags say which port it belongs to.
   assign ow_rdata = iw_mem_rdata;

   // Responses pending across a reset are discarded, so the registered flags
   // are masked during reset as well as cleared by it.
   assign or_rvalid0 = r_rvalid0 & ~iw_rst;
   assign or_rvalid1 = r_rvalid1 & ~iw_rst;
   assign or_err     = r_err & ~iw_rst;

   // Arbitration history, lock, held address and the one-cycle response stage.
   always_ff @(posedge iw_clk) begin
      if (iw_rst) begin
         r_last    <= 1'b1;
         r_locked  <= 1'b0;
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
         r_err     <= 1'b0;
         r_addr    <= '0;
      end else begin
         r_rvalid0 <= w_acc0;
         r_rvalid1 <= w_acc1 & ~iw_we1;
         r_err     <= w_rej;
         r_addr    <= ow_mem_addr;
         if (w_acc1) begin
            r_last <= 1'b1;
         end else if (w_acc0) begin
            r_last <= 1'b0;
         end
         if (w_acc1) begin
            r_locked <= iw_lock1;
         end else if (r_locked && !iw_req1) begin
            r_locked <= 1'b0;
         end
      end
   end

   // Structural invariants, usable by any checker bound to this block.
   a_one_grant : assert property (@(posedge iw_clk) disable iff (iw_rst)
      !(ow_gnt0 && ow_gnt1));
   a_we_needs_gnt1 : assert property (@(posedge iw_clk) disable iff (iw_rst)
      ow_mem_we |-> ow_gnt1);
   a_one_rvalid : assert property (@(posedge iw_clk) disable iff (iw_rst)
      !(or_rvalid0 && or_rvalid1));
   a_err_no_rvalid : assert property (@(posedge iw_clk) disable iff (iw_rst)
      or_err |-> !(or_rvalid0 || or_rvalid1));

endmodule

// File: tb/tb_mem_arb.sv
// Testbench for mem_arb: directed vector table, reset-mid-operation sequence,
// then randomized traffic checked against a transaction-level reference model.

module tb_mem_arb;

   localparam int NW = 4096;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req0;
   logic [15:0] addr0;
   logic        gnt0;
   logic        rvalid0;
   logic        req1;
   logic        we1;
   logic [15:0] addr1;
   logic [23:0] wdata1;
   logic        lock1;
   logic        gnt1;
   logic        rvalid1;
   logic [23:0] rdata;
   logic        err;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [23:0] mem_wdata;
   logic [23:0] mem_rdata;

   mem_arb #(.NUM_WORDS(NW)) dut (
      .iw_clk       (clk),
      .iw_rst       (rst),
      .iw_req0      (req0),
      .iw_addr0     (addr0),
      .ow_gnt0      (gnt0),
      .or_rvalid0   (rvalid0),
      .iw_req1      (req1),
      .iw_we1       (we1),
      .iw_addr1     (addr1),
      .iw_wdata1    (wdata1),
      .iw_lock1     (lock1),
      .ow_gnt1      (gnt1),
      .or_rvalid1   (rvalid1),
      .ow_rdata     (rdata),
      .or_err       (err),
      .ow_mem_we    (mem_we),
      .ow_mem_addr  (mem_addr),
      .ow_mem_wdata (mem_wdata),
      .iw_mem_rdata (mem_rdata)
   );

   // ---------------- external memory (read-first, 1-cycle read) ----------------
   function automatic logic [23:0] init_word(int i);
      if (i == 16) return 24'hABCDEF;
      return 24'h500000 | 24'(i);
   endfunction

   logic [23:0] mem [NW];
   logic        mem_init;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < NW; i++) mem[i] <= init_word(i);
      end else if (mem_we) begin
         mem[mem_addr[11:0]] <= mem_wdata;
      end
      mem_rdata <= mem[mem_addr[11:0]];
   end

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic r0, input logic [15:0] a0, input logic r1,
                        input logic w1, input logic [15:0] a1, input logic [23:0] d1,
                        input logic l1);
      req0 = r0; addr0 = a0; req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
   endtask

   task automatic idle();
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 24'h0, 1'b0);
   endtask

   // Reset with both ports requesting: grants, write enable and all
   // registered outputs must stay low; the memory is re-initialised meanwhile.
   task automatic do_reset(input string tag);
      rst = 1'b1;
      mem_init = 1'b1;
      drive(1'b1, 16'h0010, 1'b1, 1'b1, 16'h0020, 24'hFFFFFF, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk({tag, " rst gnt0"},    32'(gnt0),    32'd0);
      chk({tag, " rst gnt1"},    32'(gnt1),    32'd0);
      chk({tag, " rst mem_we"},  32'(mem_we),  32'd0);
      chk({tag, " rst rvalid0"}, 32'(rvalid0), 32'd0);
      chk({tag, " rst rvalid1"}, 32'(rvalid1), 32'd0);
      chk({tag, " rst err"},     32'(err),     32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      mem_init = 1'b0;
      idle();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        r0;
      logic [15:0] a0;
      logic        r1;
      logic        w1;
      logic [15:0] a1;
      logic [23:0] d1;
      logic        l1;
      logic        g0;
      logic        g1;
      logic        we;
      logic        rv0;
      logic        rv1;
      logic [23:0] rd;
      logic        er;
   } vec_t;

   localparam int NV = 25;
   vec_t vt [NV];

   function automatic vec_t mk(logic r0, logic [15:0] a0, logic r1, logic w1,
                               logic [15:0] a1, logic [23:0] d1, logic l1,
                               logic g0, logic g1, logic we, logic rv0, logic rv1,
                               logic [23:0] rd, logic er);
      vec_t v;
      v.r0 = r0; v.a0 = a0; v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.l1 = l1;
      v.g0 = g0; v.g1 = g1; v.we = we; v.rv0 = rv0; v.rv1 = rv1; v.rd = rd; v.er = er;
      return v;
   endfunction

   // ---------------- reference model state ----------------
   logic [23:0] ref_mem [NW];
   logic [24:0] exp_q [$];   // {port, data} of the read returning next cycle
   int          last_port;
   bit          locked;
   bit          exp_err;

   function automatic logic [15:0] rand_addr();
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 6)  return 16'($urandom_range(NW, 65535));
      if (r < 10) return 16'(NW - 1);
      return 16'($urandom_range(0, 63));
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      bit          p0_v;
      bit          p1_v;
      bit          p1_w;
      bit          p1_l;
      logic [15:0] p0_a;
      logic [15:0] p1_a;
      logic [23:0] p1_d;
      logic [24:0] e;
      logic [15:0] wa;
      bit          e_rv0;
      bit          e_rv1;
      bit          ok;
      logic [23:0] e_rd;
      int          win;

      rst = 1'b1;
      mem_init = 1'b1;
      idle();

      // Rows: inputs for one cycle, then the outputs expected in that cycle.
      //           r0   a0        r1   w1   a1        d1          l1    g0   g1   we   rv0  rv1  rd          err
      vt[0]  = mk(1'b1,16'h0010, 1'b0,1'b0,16'h0000,24'h000000,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,24'h000000,1'b0);
      vt[1]  = mk(1'b0,16'h0000, 1'b0,1'b0,16'h0000,24'h000000,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0,24'hABCDEF,1'b0);
      vt[2]  = mk(1'b1,16'h0000, 1'b1,1'b0,16'h0100,24'h000000,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0,24'h000000,1'b0);
      vt[3]  = mk(1'b1,16'h0000, 1'b1,1'b0,16'h0101,24'h000000,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,24'h500100,1'b0);
      vt[4]  = mk(1'b1,16'h0001, 1'b1,1'b0,16'h0101,24'h000000,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b0,24'h500000,1'b0);
      vt[5]  = mk(1'b1,16'h0001, 1'b1,1'b0,16'h0102,24'h000000,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,24'h500101,1'b0);
      vt[6]  = mk(1'b1,16'h0002, 1'b1,1'b0,16'h0102,24'h000000,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b0,24'h500001,1'b0);
      vt[7]  = mk(1'b1,16'h0002, 1'b1,1'b0,16'h0103,24'h000000,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,24'h500102,1'b0);
      vt[8]  = mk(1'b1,16'h0003, 1'b1,1'b0,16'h0103,24'h000000,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b0,24'h500002,1'b0);
      vt[9]  = mk(1'b1,16'h0003, 1'b0,1'b0,16'h0000,24'h000000,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,24'h500103,1'b0);
      vt[10] = mk(1'b0,16'h0000, 1'b0,1'b0,16'h0000,24'h000000,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0,24'h500003,1'b0);
      // write then read of the same address, both presented together
      vt[11] = mk(1'b1,16'h0020, 1'b1,1'b1,16'h0020,24'h123456,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0,24'h000000,1'b0);
      vt[12] = mk(1'b1,16'h0020, 1'b0,1'b0,16'h0000,24'h000000,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,24'h000000,1'b0);
      vt[13] = mk(1'b0,16'h0000, 1'b0,1'b0,16'h0000,24'h000000,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0,24'h123456,1'b0);
      // locked read-modify-write on port 1 while port 0 keeps requesting
      vt[14] = mk(1'b1,16'h0040, 1'b1,1'b0,16'h0030,24'h000000,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b0,24'h000000,1'b0);
      vt[15] = mk(1'b1,16'h0040, 1'b1,1'b1,16'h0030,24'h654321,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b1,24'h500030,1'b0);
      vt[16] = mk(1'b1,16'h0040, 1'b1,1'b0,16'h0031,24'h000000,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,24'h000000,1'b0);
      vt[17] = mk(1'b0,16'h0000, 1'b1,1'b0,16'h0031,24'h000000,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b0,24'h500040,1'b0);
      vt[18] = mk(1'b0,16'h0000, 1'b0,1'b0,16'h0000,24'h000000,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,24'h500031,1'b0);
      // range boundary on both ports
      vt[19] = mk(1'b1,16'h1000, 1'b0,1'b0,16'h0000,24'h000000,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,24'h000000,1'b0);
      vt[20] = mk(1'b0,16'h0000, 1'b0,1'b0,16'h0000,24'h000000,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,24'h000000,1'b1);
      vt[21] = mk(1'b1,16'h0FFF, 1'b0,1'b0,16'h0000,24'h000000,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,24'h000000,1'b0);
      vt[22] = mk(1'b0,16'h0000, 1'b0,1'b0,16'h0000,24'h000000,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0,24'h500FFF,1'b0);
      vt[23] = mk(1'b0,16'h0000, 1'b1,1'b1,16'h1000,24'h777777,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0,24'h000000,1'b0);
      vt[24] = mk(1'b0,16'h0000, 1'b0,1'b0,16'h0000,24'h000000,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,24'h000000,1'b1);

      do_reset("r0");

      for (int i = 0; i < NV; i++) begin
         drive(vt[i].r0, vt[i].a0, vt[i].r1, vt[i].w1, vt[i].a1, vt[i].d1, vt[i].l1);
         @(negedge clk);
         chk($sformatf("v%0d gnt0", i),    32'(gnt0),    32'(vt[i].g0));
         chk($sformatf("v%0d gnt1", i),    32'(gnt1),    32'(vt[i].g1));
         chk($sformatf("v%0d mem_we", i),  32'(mem_we),  32'(vt[i].we));
         chk($sformatf("v%0d rvalid0", i), 32'(rvalid0), 32'(vt[i].rv0));
         chk($sformatf("v%0d rvalid1", i), 32'(rvalid1), 32'(vt[i].rv1));
         chk($sformatf("v%0d err", i),     32'(err),     32'(vt[i].er));
         if (vt[i].rv0 || vt[i].rv1) begin
            chk($sformatf("v%0d rdata", i), 32'(rdata), 32'(vt[i].rd));
         end
         @(posedge clk);
         #1;
      end

      // Reset one cycle after a locked port-1 read grant: the response is
      // dropped and the lock cleared, so the next tie goes to port 0.
      drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0050, 24'h0, 1'b1);
      @(negedge clk);
      chk("mid gnt1", 32'(gnt1), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle();
      @(negedge clk);
      chk("mid rvalid1 in reset", 32'(rvalid1), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(1'b1, 16'h0060, 1'b1, 1'b0, 16'h0061, 24'h0, 1'b0);
      @(negedge clk);
      chk("mid rvalid1 after", 32'(rvalid1), 32'd0);
      chk("mid tie gnt0", 32'(gnt0), 32'd1);
      chk("mid tie gnt1", 32'(gnt1), 32'd0);
      @(posedge clk);
      #1;
      drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0061, 24'h0, 1'b0);
      @(negedge clk);
      chk("mid rvalid0", 32'(rvalid0), 32'd1);
      chk("mid rdata0", 32'(rdata), 32'h500060);
      chk("mid gnt1 next", 32'(gnt1), 32'd1);
      @(posedge clk);
      #1;
      idle();
      @(negedge clk);
      chk("mid rvalid1 final", 32'(rvalid1), 32'd1);
      chk("mid rdata1", 32'(rdata), 32'h500061);
      @(posedge clk);
      #1;

      // ---------------- randomized traffic vs. reference model ----------------
      do_reset("r1");
      for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
      exp_q.delete();
      last_port = 1;
      locked    = 1'b0;
      exp_err   = 1'b0;
      p0_v = 1'b0; p1_v = 1'b0; p1_w = 1'b0; p1_l = 1'b0;
      p0_a = '0; p1_a = '0; p1_d = '0;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!p0_v && $urandom_range(0, 99) < 60) begin
            p0_v = 1'b1;
            p0_a = rand_addr();
         end else if (p0_v && $urandom_range(0, 99) < 5) begin
            p0_v = 1'b0;
         end
         if (!p1_v && $urandom_range(0, 99) < 60) begin
            p1_v = 1'b1;
            p1_w = ($urandom_range(0, 99) < 40);
            p1_l = ($urandom_range(0, 99) < 30);
            p1_a = rand_addr();
            p1_d = 24'($urandom);
         end else if (p1_v && $urandom_range(0, 99) < 5) begin
            p1_v = 1'b0;
         end
         drive(p0_v, p0_a, p1_v, p1_w, p1_a, p1_d, p1_l);

         @(negedge clk);
         // response expected this cycle from last cycle's accepted read
         e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd = '0;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e[24]) e_rv1 = 1'b1;
            else       e_rv0 = 1'b1;
            e_rd = e[23:0];
         end
         // who wins: lone requester, else lock, else whoever did not go last
         win = -1;
         if (p0_v && p1_v) win = locked ? 1 : 1 - last_port;
         else if (p0_v)    win = 0;
         else if (p1_v)    win = 1;
         wa = (win == 1) ? p1_a : p0_a;
         ok = (int'(wa) < NW);

         chk($sformatf("c%0d gnt0", cyc),    32'(gnt0),    32'(win == 0));
         chk($sformatf("c%0d gnt1", cyc),    32'(gnt1),    32'(win == 1));
         chk($sformatf("c%0d mem_we", cyc),  32'(mem_we),  32'(win == 1 && ok && p1_w));
         chk($sformatf("c%0d rvalid0", cyc), 32'(rvalid0), 32'(e_rv0));
         chk($sformatf("c%0d rvalid1", cyc), 32'(rvalid1), 32'(e_rv1));
         chk($sformatf("c%0d err", cyc),     32'(err),     32'(exp_err));
         if (e_rv0 || e_rv1) begin
            chk($sformatf("c%0d rdata", cyc), 32'(rdata), 32'(e_rd));
         end
         if (win >= 0 && ok) begin
            chk($sformatf("c%0d mem_addr", cyc), 32'(mem_addr), 32'(wa));
            if (win == 1 && p1_w) begin
               chk($sformatf("c%0d mem_wdata", cyc), 32'(mem_wdata), 32'(p1_d));
            end
         end

         // advance the model by one transfer
         exp_err = (win >= 0) && !ok;
         if (win >= 0 && ok) begin
            last_port = win;
            if (win == 1 && p1_w) ref_mem[wa[11:0]] = p1_d;
            else exp_q.push_back({(win == 1), ref_mem[wa[11:0]]});
         end
         if (win == 1 && ok)         locked = p1_l;
         else if (locked && !p1_v)   locked = 1'b0;
         if (win == 0) p0_v = 1'b0;
         if (win == 1) p1_v = 1'b0;

         @(posedge clk);
         #1;
      end

      idle();
      @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
